// File: rtl/bagman_pkg.sv
// Shared loader state encoding and ROM/PROM address map for the Bagman ROM loader.
package bagman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_SETTLE,
    ST_RUN,
    ST_FAIL
  } loader_state_t;

  localparam int REGION_CPU    = 0;
  localparam int REGION_GFX    = 1;
  localparam int REGION_SPEECH = 2;
  localparam int REGION_PROM   = 3;
  localparam int NUM_REGIONS   = 4;

  localparam logic [16:0] CPU_BASE     = 17'h00000;
  localparam logic [16:0] CPU_LIMIT    = 17'h05FFF;
  localparam logic [16:0] GFX_BASE     = 17'h06000;
  localparam logic [16:0] GFX_LIMIT    = 17'h0DFFF;
  localparam logic [16:0] SPEECH_BASE  = 17'h0E000;
  localparam logic [16:0] SPEECH_LIMIT = 17'h0FFFF;
  localparam logic [16:0] PROM_BASE    = 17'h10000;
  localparam logic [16:0] PROM_LIMIT   = 17'h1003F;

  function automatic logic in_range(input logic [16:0] a, input logic [16:0] lo,
                                    input logic [16:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/bagman_region_decode.sv
// Byte address to one-hot region select; unmapped addresses select nothing.
module bagman_region_decode
  import bagman_pkg::*;
(
  input  logic [16:0]            addr_i,
  output logic [NUM_REGIONS-1:0] sel_o
);

  always_comb begin
    sel_o = '0;
    if (in_range(addr_i, CPU_BASE, CPU_LIMIT))       sel_o[REGION_CPU]    = 1'b1;
    if (in_range(addr_i, GFX_BASE, GFX_LIMIT))       sel_o[REGION_GFX]    = 1'b1;
    if (in_range(addr_i, SPEECH_BASE, SPEECH_LIMIT)) sel_o[REGION_SPEECH] = 1'b1;
    if (in_range(addr_i, PROM_BASE, PROM_LIMIT))     sel_o[REGION_PROM]   = 1'b1;
  end

endmodule

// File: rtl/bagman_rom_loader.sv
// Bagman ROM download sequencer and shared memory-port arbiter.
// Optional image checksum check: define BAGMAN_ROM_CHECKSUM_EN.
module bagman_rom_loader
  import bagman_pkg::*;
#(
  parameter logic [16:0] IMAGE_BYTES   = 17'h10040,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] IMAGE_SUM     = 16'h0000
)(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [16:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        core_reset,
  output logic        rom_ok,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  input  logic [7:0]  mem_rdata,
  input  logic        cpu_rd_req,
  input  logic [16:0] cpu_rd_addr,
  output logic        cpu_rd_ack,
  output logic        cpu_rd_valid,
  output logic [7:0]  cpu_rd_data
);

  localparam logic [17:0] IMG_LEN = {1'b0, IMAGE_BYTES};
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  loader_state_t state_q, state_d;
  logic          dl_q, dl_prev_q;
  logic [17:0]   count_q, count_d;
  logic          err_q, err_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          rom_ok_q, rom_ok_d;
  logic          core_reset_q;
  logic [16:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_sel_q, mem_sel_d;
  logic          rd_pend_q, rd_valid_q;

  logic        dl_rise, dl_fall, load_start;
  logic        wr_ld, wr_bad, rd_ack, sum_ok;
  logic [16:0] dec_addr;
  logic [3:0]  dec_sel;

  assign dl_rise    = dl_q & ~dl_prev_q;
  assign dl_fall    = ~dl_q & dl_prev_q;
  assign load_start = dl_rise &&
                      (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_FAIL);
  assign wr_ld      = (state_q == ST_LOAD) && dn_wr;
  assign wr_bad     = ({1'b0, dn_addr} != count_q) || (count_q >= IMG_LEN);
  assign rd_ack     = (state_q == ST_RUN) && cpu_rd_req;

  // One decoder serves both paths: writes only happen in LOAD, reads only in RUN.
  assign dec_addr = (state_q == ST_LOAD) ? dn_addr : cpu_rd_addr;

  bagman_region_decode u_decode (
    .addr_i (dec_addr),
    .sel_o  (dec_sel)
  );

`ifdef BAGMAN_ROM_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_start)            sum_d = '0;
    else if (wr_ld && !wr_bad) sum_d = sum_q + {8'h00, dn_data};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign sum_ok = (sum_q == IMAGE_SUM);
`else
  logic unused_sum;
  assign unused_sum = ^IMAGE_SUM;
  assign sum_ok     = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    settle_d = settle_q;
    rom_ok_d = rom_ok_q;
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_FAIL: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          count_d  = '0;
          err_d    = 1'b0;
          rom_ok_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (wr_ld) begin
          if (wr_bad) err_d   = 1'b1;
          else        count_d = count_q + 18'd1;
        end
        if (dl_fall) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (count_q == IMG_LEN && !err_q && sum_ok) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LAST;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d  = ST_RUN;
          rom_ok_d = 1'b1;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port keeps its last address/select when idle; only mem_we is pulsed.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    mem_we_d    = 1'b0;
    if (wr_ld) begin
      mem_addr_d  = dn_addr;
      mem_wdata_d = dn_data;
      mem_sel_d   = dec_sel;
      mem_we_d    = !wr_bad;
    end else if (rd_ack) begin
      mem_addr_d = cpu_rd_addr;
      mem_sel_d  = dec_sel;
    end
  end

  // dl_q/dl_prev_q reset high so a download already running at reset release is not taken as a new edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      dl_q         <= 1'b1;
      dl_prev_q    <= 1'b1;
      count_q      <= '0;
      err_q        <= 1'b0;
      settle_q     <= '0;
      rom_ok_q     <= 1'b0;
      core_reset_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= '0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dn_download;
      dl_prev_q    <= dl_q;
      count_q      <= count_d;
      err_q        <= err_d;
      settle_q     <= settle_d;
      rom_ok_q     <= rom_ok_d;
      core_reset_q <= (state_d != ST_RUN);
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      rd_pend_q    <= rd_ack;
      rd_valid_q   <= rd_pend_q;
    end
  end

  assign core_reset   = core_reset_q;
  assign rom_ok       = rom_ok_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign mem_sel      = mem_sel_q;
  assign cpu_rd_ack   = rd_ack;
  assign cpu_rd_valid = rd_valid_q;
  assign cpu_rd_data  = mem_rdata;

endmodule

// File: tb/tb_bagman_rom_loader.sv
// Directed bench for bagman_rom_loader: full image, RUN reads, reload, address skip, async reset.
module tb_bagman_rom_loader;

  localparam int S = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [16:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        core_reset, rom_ok, mem_we, cpu_rd_ack, cpu_rd_valid;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, cpu_rd_data;
  logic [3:0]  mem_sel;
  logic        cpu_rd_req = 1'b0;
  logic [16:0] cpu_rd_addr = '0;

  bit [7:0] mem [0:131071];
  int checks = 0;
  int errors = 0;

  bagman_rom_loader #(
    .IMAGE_BYTES   (17'h10040),
    .SETTLE_CYCLES (S),
    .IMAGE_SUM     (16'h1234)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .dn_download  (dn_download),
    .dn_wr        (dn_wr),
    .dn_addr      (dn_addr),
    .dn_data      (dn_data),
    .core_reset   (core_reset),
    .rom_ok       (rom_ok),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_rdata    (mem_rdata),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_ack   (cpu_rd_ack),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rd_data  (cpu_rd_data)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk_sys) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Image bytes sum to 16'h1235: 17*FF + A1 + A5.
  function automatic logic [7:0] img(input int a);
    if (a < 17)       return 8'hFF;
    if (a == 17)      return 8'hA1;
    if (a == 'h6000)  return 8'hA5;
    return 8'h00;
  endfunction

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 17'h06000;
    #12;
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got %b exp 1", core_reset); end
    checks++; if (rom_ok !== 1'b0) begin errors++; $display("FAIL rst_rom_ok got %b exp 0", rom_ok); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_sel !== 4'b0000) begin errors++; $display("FAIL rst_mem_sel got %b exp 0000", mem_sel); end
    checks++; if (mem_addr !== 17'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (cpu_rd_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", cpu_rd_ack); end
    checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", cpu_rd_valid); end
    step;
    reset_n = 1'b1;
    step;
    step;
    checks++; if (cpu_rd_ack !== 1'b0) begin errors++; $display("FAIL idle_ack got %b exp 0", cpu_rd_ack); end
  endtask

  task automatic test_full_load;
    dn_download = 1'b1;
    step;
    step;
    for (int a = 0; a < 'h10040; a++) begin
      dn_wr   = 1'b1;
      dn_addr = 17'(a);
      dn_data = img(a);
      if (a == 'h1003F) dn_download = 1'b0;
      step;
      if (a == 0) begin
        checks++; if (mem_sel !== 4'b0001 || mem_we !== 1'b1) begin errors++; $display("FAIL wr0 sel/we got %b/%b exp 0001/1", mem_sel, mem_we); end
        checks++; if (cpu_rd_ack !== 1'b0) begin errors++; $display("FAIL load_ack got %b exp 0", cpu_rd_ack); end
      end
      if (a == 'h6000) begin
        checks++; if (mem_sel !== 4'b0010 || mem_addr !== 17'h06000 || mem_wdata !== 8'hA5 || mem_we !== 1'b1)
          begin errors++; $display("FAIL wr_gfx got sel %b addr %h data %h we %b exp 0010 06000 a5 1", mem_sel, mem_addr, mem_wdata, mem_we); end
      end
      if (a == 'hE000) begin
        checks++; if (mem_sel !== 4'b0100) begin errors++; $display("FAIL wr_speech_sel got %b exp 0100", mem_sel); end
      end
      if (a == 'h1003F) begin
        checks++; if (mem_sel !== 4'b1000 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_prom_last sel/we got %b/%b exp 1000/1", mem_sel, mem_we); end
      end
    end
    dn_wr = 1'b0;
    for (int k = 1; k <= S + 1; k++) step;
    checks++; if (core_reset !== 1'b1 || rom_ok !== 1'b0 || cpu_rd_ack !== 1'b0)
      begin errors++; $display("FAIL settle_last got rst %b ok %b ack %b exp 1 0 0", core_reset, rom_ok, cpu_rd_ack); end
    step;
`ifdef BAGMAN_ROM_CHECKSUM_EN
    checks++; if (core_reset !== 1'b1 || rom_ok !== 1'b0 || cpu_rd_ack !== 1'b0)
      begin errors++; $display("FAIL sum_mismatch got rst %b ok %b ack %b exp 1 0 0", core_reset, rom_ok, cpu_rd_ack); end
    cpu_rd_req = 1'b0;
`else
    checks++; if (core_reset !== 1'b0 || rom_ok !== 1'b1) begin errors++; $display("FAIL release got rst %b ok %b exp 0 1", core_reset, rom_ok); end
    checks++; if (cpu_rd_ack !== 1'b1) begin errors++; $display("FAIL first_run_ack got %b exp 1", cpu_rd_ack); end
    step;
    cpu_rd_req = 1'b0;
    checks++; if (mem_sel !== 4'b0010 || mem_addr !== 17'h06000 || mem_we !== 1'b0)
      begin errors++; $display("FAIL rd_port got sel %b addr %h we %b exp 0010 06000 0", mem_sel, mem_addr, mem_we); end
    step;
    checks++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 8'hA5) begin errors++; $display("FAIL rd_gfx got v %b d %h exp 1 a5", cpu_rd_valid, cpu_rd_data); end
`endif
  endtask

  task automatic test_back_to_back;
    step;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 17'h00011;
    #1;
    checks++; if (cpu_rd_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack0 got %b exp 1", cpu_rd_ack); end
    step;
    cpu_rd_addr = 17'h10040;
    #1;
    checks++; if (cpu_rd_ack !== 1'b1 || mem_sel !== 4'b0001 || mem_addr !== 17'h00011)
      begin errors++; $display("FAIL b2b_1 got ack %b sel %b addr %h exp 1 0001 00011", cpu_rd_ack, mem_sel, mem_addr); end
    step;
    cpu_rd_req = 1'b0;
    checks++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 8'hA1 || mem_sel !== 4'b0000)
      begin errors++; $display("FAIL b2b_2 got v %b d %h sel %b exp 1 a1 0000", cpu_rd_valid, cpu_rd_data, mem_sel); end
    step;
    checks++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 8'h00) begin errors++; $display("FAIL b2b_3 got v %b d %h exp 1 00", cpu_rd_valid, cpu_rd_data); end
    step;
    checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", cpu_rd_valid); end
  endtask

  task automatic test_reload;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 17'h06000;
    dn_download = 1'b1;
    #1;
    checks++; if (cpu_rd_ack !== 1'b1) begin errors++; $display("FAIL reload_ack_d got %b exp 1", cpu_rd_ack); end
    step;
    checks++; if (cpu_rd_ack !== 1'b1 || core_reset !== 1'b0) begin errors++; $display("FAIL reload_edge got ack %b rst %b exp 1 0", cpu_rd_ack, core_reset); end
    step;
    checks++; if (cpu_rd_ack !== 1'b0 || core_reset !== 1'b1 || rom_ok !== 1'b0)
      begin errors++; $display("FAIL reload_enter got ack %b rst %b ok %b exp 0 1 0", cpu_rd_ack, core_reset, rom_ok); end
    checks++; if (cpu_rd_valid !== 1'b1) begin errors++; $display("FAIL reload_valid0 got %b exp 1", cpu_rd_valid); end
    step;
    checks++; if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 8'hA5) begin errors++; $display("FAIL reload_valid1 got v %b d %h exp 1 a5", cpu_rd_valid, cpu_rd_data); end
    cpu_rd_req = 1'b0;
    for (int a = 0; a < 4; a++) begin
      dn_wr   = 1'b1;
      dn_addr = 17'(a);
      dn_data = 8'h5A;
      if (a == 3) dn_download = 1'b0;
      step;
    end
    dn_wr = 1'b0;
    for (int k = 0; k < S + 6; k++) step;
    checks++; if (core_reset !== 1'b1 || rom_ok !== 1'b0) begin errors++; $display("FAIL short_image got rst %b ok %b exp 1 0", core_reset, rom_ok); end
  endtask

  task automatic test_addr_skip;
    logic [16:0] seq [6];
    seq = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd5, 17'd6};
    dn_download = 1'b1;
    step;
    step;
    for (int i = 0; i < 6; i++) begin
      dn_wr   = 1'b1;
      dn_addr = seq[i];
      dn_data = 8'h11;
      if (i == 5) dn_download = 1'b0;
      step;
      if (i == 3) begin
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL skip_before got we %b exp 1", mem_we); end
      end
      if (i == 4) begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL skip_suppress got we %b exp 0", mem_we); end
      end
    end
    dn_wr = 1'b0;
    for (int k = 0; k < S + 6; k++) step;
    checks++; if (core_reset !== 1'b1 || rom_ok !== 1'b0) begin errors++; $display("FAIL skip_final got rst %b ok %b exp 1 0", core_reset, rom_ok); end
    cpu_rd_req = 1'b1;
    #1;
    checks++; if (cpu_rd_ack !== 1'b0) begin errors++; $display("FAIL fail_ack got %b exp 0", cpu_rd_ack); end
    cpu_rd_req = 1'b0;
    dn_wr   = 1'b1;
    dn_addr = 17'd0;
    step;
    dn_wr = 1'b0;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_outside_load got %b exp 0", mem_we); end
  endtask

  task automatic test_reset_midload;
    dn_download = 1'b1;
    step;
    step;
    for (int a = 0; a < 2; a++) begin
      dn_wr   = 1'b1;
      dn_addr = 17'(a);
      dn_data = 8'h77;
      step;
    end
    dn_addr = 17'd2;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 17'h0 || mem_wdata !== 8'h0 || mem_sel !== 4'b0)
      begin errors++; $display("FAIL async_rst_port got we %b addr %h data %h sel %b exp 0 0 0 0", mem_we, mem_addr, mem_wdata, mem_sel); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL async_rst_core got %b exp 1", core_reset); end
    step;
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      dn_addr = 17'(a);
      step;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL no_resume_%0d got we %b exp 0", a, mem_we); end
    end
    dn_wr       = 1'b0;
    dn_download = 1'b0;
    step;
    checks++; if (core_reset !== 1'b1 || rom_ok !== 1'b0) begin errors++; $display("FAIL no_resume_state got rst %b ok %b exp 1 0", core_reset, rom_ok); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_load();
`ifndef BAGMAN_ROM_CHECKSUM_EN
    test_back_to_back();
    test_reload();
`endif
    test_addr_skip();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
